mul_div_unit: RTL and testbench

- Multiply/divide unit in the E stage, directly downstream of the decoder.
- Consumes the decoder's 6-bit instruction type code and `start` strobe, carried down the pipeline to E.
- Holds the architectural HI/LO registers, models multi-cycle mult/div latency with a busy counter, and serves MFHI/MFLO reads.
- Raises the D-stage stall request for MD-class instructions while an operation is pending.

---
 rtl/mul_div_unit_pkg.sv | 33 +++
 rtl/mul_div_unit_if.sv | 34 +++
 rtl/mul_div_unit.sv | 133 +++++++++++++
 tb/tb_mul_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the 6-bit instruction type codes (shared with the decoder), the
// bubble code, the default operation latencies and small decode helpers.
package mul_div_unit_pkg;

    localparam int TYPE_W = 6;

    localparam logic [TYPE_W-1:0] TYPE_MULT   = 6'h15;
    localparam logic [TYPE_W-1:0] TYPE_MULTU  = 6'h16;
    localparam logic [TYPE_W-1:0] TYPE_DIV    = 6'h17;
    localparam logic [TYPE_W-1:0] TYPE_DIVU   = 6'h18;
    localparam logic [TYPE_W-1:0] TYPE_MFHI   = 6'h19;
    localparam logic [TYPE_W-1:0] TYPE_MFLO   = 6'h1A;
    localparam logic [TYPE_W-1:0] TYPE_MTHI   = 6'h1B;
    localparam logic [TYPE_W-1:0] TYPE_MTLO   = 6'h1C;
    localparam logic [TYPE_W-1:0] TYPE_BUBBLE = 6'h3F;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    localparam int CNT_W = 4;

    // True for the four type codes that launch a multi-cycle operation.
    function automatic logic is_md_op(input logic [TYPE_W-1:0] t);
        return (t == TYPE_MULT) || (t == TYPE_MULTU) ||
               (t == TYPE_DIV)  || (t == TYPE_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [TYPE_W-1:0] t);
        return (t == TYPE_MULT) || (t == TYPE_MULTU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Signal bundle between the E-stage pipeline / hazard unit and the
// multiply/divide unit.
//   slave  : the unit itself (takes E-stage operands, drives HI/LO, status)
//   master : the pipeline side (drives operands, observes results)
// Handshake: e_start is a one-cycle request; it is accepted at a posedge
// only when busy==0 (ready = !busy). A request while busy is dropped, and
// the hazard unit uses md_stall to keep that from happening.
// count exposes the latency counter for observation.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic [TYPE_W-1:0] e_type;
    logic              e_start;
    logic [31:0]       e_rs;
    logic [31:0]       e_rt;
    logic              d_is_md;
    logic              busy;
    logic              md_stall;
    logic [31:0]       hi;
    logic [31:0]       lo;
    logic [31:0]       md_out;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  e_type, e_start, e_rs, e_rt, d_is_md,
        output busy, md_stall, hi, lo, md_out, count
    );

    modport master (
        output e_type, e_start, e_rs, e_rt, d_is_md,
        input  busy, md_stall, hi, lo, md_out, count
    );

endinterface

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit.
// Holds architectural HI/LO, computes MULT/MULTU/DIV/DIVU results in the
// accept cycle into pending registers, and models latency with a 4-bit
// down-counter; HI/LO take the pending result on the edge where the
// counter goes 1->0. Also serves MFHI/MFLO and MTHI/MTLO, and raises the
// D-stage stall request for MD-class instructions while work is pending.
// Ports:
//   clk   : system clock, all state updates on posedge
//   reset : synchronous active-low reset
//   md    : mul_div_unit_if.slave (operands, type, start, status, HI/LO)
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave md
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             busy_w;
    logic             start_ok;

    // ---------------- arithmetic (evaluated every cycle) ----------------
    logic [63:0] prod_s, prod_u;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, rt_mag_safe, rt_safe;
    logic [31:0] uq_mag, ur_mag, sq, sr, uq, ur;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        prod_s = $signed({{32{md.e_rs[31]}}, md.e_rs}) *
                 $signed({{32{md.e_rt[31]}}, md.e_rt});
        prod_u = {32'd0, md.e_rs} * {32'd0, md.e_rt};

        // Signed divide done on magnitudes: truncation toward zero falls
        // out naturally, and 0x80000000 / -1 yields 0x80000000 rem 0
        // without relying on overflow behaviour of a signed divider.
        rs_neg      = md.e_rs[31];
        rt_neg      = md.e_rt[31];
        rs_mag      = rs_neg ? (~md.e_rs + 32'd1) : md.e_rs;
        rt_mag      = rt_neg ? (~md.e_rt + 32'd1) : md.e_rt;
        rt_mag_safe = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        rt_safe     = (md.e_rt == 32'd0) ? 32'd1 : md.e_rt;
        uq_mag      = rs_mag / rt_mag_safe;
        ur_mag      = rs_mag % rt_mag_safe;
        sq          = (rs_neg ^ rt_neg) ? (~uq_mag + 32'd1) : uq_mag;
        sr          = rs_neg ? (~ur_mag + 32'd1) : ur_mag;
        uq          = md.e_rs / rt_safe;
        ur          = md.e_rs % rt_safe;

        res_hi = hi_q;
        res_lo = lo_q;
        case (md.e_type)
            TYPE_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            TYPE_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            TYPE_DIV:   if (md.e_rt != 32'd0) begin res_hi = sr; res_lo = sq; end
            TYPE_DIVU:  if (md.e_rt != 32'd0) begin res_hi = ur; res_lo = uq; end
            default:    begin res_hi = hi_q; res_lo = lo_q; end
        endcase
        // Divide by zero keeps the current HI/LO as the pending result, so
        // the commit after the full latency leaves them unchanged.
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        busy_w    = (cnt_q != '0);
        start_ok  = md.e_start && !busy_w && is_md_op(md.e_type);
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        if (busy_w) begin
            cnt_d = cnt_q - 1'b1;
            // Commit on the last busy edge; MTHI/MTLO are blocked while
            // busy so nothing else can write HI/LO here.
            if (cnt_q == CNT_W'(1)) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (start_ok) begin
            cnt_d     = is_mult_op(md.e_type) ? MULT_LOAD : DIV_LOAD;
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
        end else if (md.e_type == TYPE_MTHI) begin
            hi_d = md.e_rs;
        end else if (md.e_type == TYPE_MTLO) begin
            lo_d = md.e_rs;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        md.busy     = (cnt_q != '0);
        // e_start term covers the accept cycle, before busy has risen.
        md.md_stall = md.d_is_md & ((cnt_q != '0) | md.e_start);
        md.hi       = hi_q;
        md.lo       = lo_q;
        md.count    = cnt_q;
        case (md.e_type)
            TYPE_MFHI: md.md_out = hi_q;
            TYPE_MFLO: md.md_out = lo_q;
            default:   md.md_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a table of arithmetic vectors with
// hand-computed HI/LO and latency, plus hand-written sequences for reset,
// divide-by-zero, stall, MTHI/MTLO/MF and reset during an operation.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    mul_div_unit_if bus ();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[9];

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        bus.e_type  = TYPE_BUBBLE;
        bus.e_start = 1'b0;
        bus.e_rs    = 32'd0;
        bus.e_rt    = 32'd0;
    endtask

    // Write HI or LO through MTHI/MTLO in one cycle.
    task automatic move_to(input logic [5:0] op, input logic [31:0] val);
        bus.e_type = op;
        bus.e_rs   = val;
        tick();
        idle_inputs();
    endtask

    // Issue one op, count busy cycles (bounded), check latency and HI/LO.
    task automatic run_op(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int cyc, input string name);
        int n;
        bus.e_type  = op;
        bus.e_start = 1'b1;
        bus.e_rs    = rs;
        bus.e_rt    = rt;
        #1;
        check({name, " busy_at_start"}, 32'(bus.busy), 32'd0);
        tick();
        idle_inputs();
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            tick();
        end
        check({name, " busy_cycles"}, 32'(n), 32'(cyc));
        check({name, " hi"}, bus.hi, exp_hi);
        check({name, " lo"}, bus.lo, exp_lo);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{TYPE_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{TYPE_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{TYPE_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{TYPE_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4] = '{TYPE_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
        vecs[5] = '{TYPE_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[6] = '{TYPE_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[7] = '{TYPE_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8] = '{TYPE_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        // Reset held for 2 cycles with a start request present.
        reset       = 1'b0;
        bus.d_is_md = 1'b0;
        bus.e_type  = TYPE_MULT;
        bus.e_start = 1'b1;
        bus.e_rs    = 32'd5;
        bus.e_rt    = 32'd5;
        tick();
        tick();
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset count", 32'(bus.count), 32'd0);
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("post_reset busy", 32'(bus.busy), 32'd0);

        // Table of arithmetic vectors, each followed by MFHI/MFLO reads.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo,
                   vecs[i].cyc, $sformatf("vec%0d", i));
            bus.e_type = TYPE_MFHI;
            #1;
            check($sformatf("vec%0d mfhi", i), bus.md_out, vecs[i].hi);
            bus.e_type = TYPE_MFLO;
            #1;
            check($sformatf("vec%0d mflo", i), bus.md_out, vecs[i].lo);
            idle_inputs();
            tick();
        end

        // Divide by zero leaves HI/LO untouched after the full latency.
        move_to(TYPE_MTHI, 32'h11);
        move_to(TYPE_MTLO, 32'h22);
        run_op(TYPE_DIV, 32'h00000005, 32'h00000000, 32'h11, 32'h22, 10, "div0");

        // Stall: start cycle plus 5 busy cycles, then released.
        bus.d_is_md = 1'b1;
        bus.e_type  = TYPE_MULT;
        bus.e_start = 1'b1;
        bus.e_rs    = 32'd3;
        bus.e_rt    = 32'd4;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("stall c%0d", c), 32'(bus.md_stall), (c < 6) ? 32'd1 : 32'd0);
            tick();
            idle_inputs();
        end
        bus.d_is_md = 1'b0;
        bus.e_type  = TYPE_MULT;
        bus.e_start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            check($sformatf("nostall c%0d", c), 32'(bus.md_stall), 32'd0);
            tick();
            idle_inputs();
        end

        // MTHI then MFHI; bubble and MTHI themselves read as 0.
        move_to(TYPE_MTHI, 32'hDEADBEEF);
        bus.e_type = TYPE_MFHI;
        #1;
        check("mthi mfhi", bus.md_out, 32'hDEADBEEF);
        bus.e_type = TYPE_BUBBLE;
        #1;
        check("bubble md_out", bus.md_out, 32'd0);
        bus.e_type = TYPE_MTHI;
        #1;
        check("mthi md_out", bus.md_out, 32'd0);
        idle_inputs();

        // MTLO while busy is dropped; the later commit still lands.
        move_to(TYPE_MTLO, 32'hCAFE);
        check("mtlo idle", bus.lo, 32'hCAFE);
        bus.e_type  = TYPE_MULT;
        bus.e_start = 1'b1;
        bus.e_rs    = 32'd2;
        bus.e_rt    = 32'd3;
        tick();
        idle_inputs();
        move_to(TYPE_MTLO, 32'h1234);
        check("mtlo busy lo", bus.lo, 32'hCAFE);
        move_to(TYPE_MTHI, 32'h5678);
        check("mthi busy hi", bus.hi, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) tick();
        check("mul_after_mtlo hi", bus.hi, 32'd0);
        check("mul_after_mtlo lo", bus.lo, 32'd6);

        // Reset during busy cycle 4 of a DIV aborts without commit.
        move_to(TYPE_MTHI, 32'h99);
        bus.e_type  = TYPE_DIVU;
        bus.e_start = 1'b1;
        bus.e_rs    = 32'd100;
        bus.e_rt    = 32'd7;
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) tick();
        check("mid busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        for (int c = 0; c < 12; c++) tick();
        check("abort later busy", 32'(bus.busy), 32'd0);
        check("abort later hi", bus.hi, 32'd0);
        check("abort later lo", bus.lo, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
